// File: rtl/div_seq.sv
// div_seq: sequential radix-2 restoring divider with run-time signed/unsigned
// mode, divide-by-zero and signed-overflow flags. One quotient bit is produced
// per clock; results are registered and only change on the FIX edge or reset.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sign,
    input  logic             start,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             ready,
    output logic             dbz,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] prem;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             dbz_p;
    logic             ovf_p;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             borrow;

    // Operand magnitudes and one restoring step. The partial remainder keeps
    // its top bit in a WIDTH+1-bit word so unsigned divisors near 2^WIDTH
    // never lose the bit shifted out of the remainder register.
    always_comb begin
        a_mag   = (sign && a[WIDTH-1]) ? -a : a;
        b_mag   = (sign && b[WIDTH-1]) ? -b : b;
        partial = {prem, dvd[WIDTH-1]};
        diff    = partial - {1'b0, dsr};
        borrow  = diff[WIDTH];
    end

    // Control FSM and datapath: accept in IDLE, iterate in CALC, apply the
    // recorded sign corrections and publish the results in FIX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            dvd   <= '0;
            dsr   <= '0;
            prem  <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dbz_p <= 1'b0;
            ovf_p <= 1'b0;
            quot  <= '0;
            rem   <= '0;
            ready <= 1'b1;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        neg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r <= sign & a[WIDTH-1];
                        dsr   <= b_mag;
                        prem  <= '0;
                        cnt   <= '0;
                        ready <= 1'b0;
                        if (b == '0) begin
                            dvd   <= a;
                            dbz_p <= 1'b1;
                            ovf_p <= 1'b0;
                            state <= FIX;
                        end else begin
                            dvd   <= a_mag;
                            dbz_p <= 1'b0;
                            ovf_p <= sign && (a == MOST_NEG) && (b == '1);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem  <= borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
                    dvd   <= {dvd[WIDTH-2:0], ~borrow};
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dbz_p) begin
                        quot <= '1;
                        rem  <= dvd;
                    end else begin
                        quot <= neg_q ? -dvd : dvd;
                        rem  <= neg_r ? -prem : prem;
                    end
                    dbz   <= dbz_p;
                    ovf   <= ovf_p;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: drives a 32-bit and an 8-bit div_seq side by side and compares
// every result against an arithmetic reference model of integer division.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic [31:0] a32, b32, quot32, rem32;
    logic        sign32, start32, ready32, dbz32, ovf32;
    logic [7:0]  a8, b8, quot8, rem8;
    logic        sign8, start8, ready8, dbz8, ovf8;

    int vectors;
    int miscompares;

    div_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .a(a32), .b(b32), .sign(sign32), .start(start32),
        .quot(quot32), .rem(rem32), .ready(ready32), .dbz(dbz32), .ovf(ovf32)
    );

    div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .sign(sign8), .start(start8),
        .quot(quot8), .rem(rem8), .ready(ready8), .dbz(dbz8), .ovf(ovf8)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic cur_ready(input int w);
        return (w == 32) ? ready32 : ready8;
    endfunction

    task automatic drive(input int w, input logic [63:0] av, input logic [63:0] bv,
                         input logic sv, input logic st);
        if (w == 32) begin
            a32 = av[31:0]; b32 = bv[31:0]; sign32 = sv; start32 = st;
        end else begin
            a8 = av[7:0]; b8 = bv[7:0]; sign8 = sv; start8 = st;
        end
    endtask

    task automatic read_out(input int w, output logic [63:0] q, output logic [63:0] r,
                            output logic z, output logic o);
        q = (w == 32) ? 64'(quot32) : 64'(quot8);
        r = (w == 32) ? 64'(rem32)  : 64'(rem8);
        z = (w == 32) ? dbz32 : dbz8;
        o = (w == 32) ? ovf32 : ovf8;
    endtask

    // Reference: plain integer division on 64-bit values, masked to w bits.
    task automatic ref_div(input int w, input logic [63:0] ai, input logic [63:0] bi,
                           input logic sv, output logic [63:0] q, output logic [63:0] r,
                           output logic z, output logic o);
        logic [63:0] mask, av, bv;
        longint sa, sb, mn;
        mask = (64'd1 << w) - 64'd1;
        av = ai & mask;
        bv = bi & mask;
        z = 1'b0;
        o = 1'b0;
        if (bv == 64'd0) begin
            q = mask; r = av; z = 1'b1;
        end else if (!sv) begin
            q = av / bv; r = av % bv;
        end else begin
            sa = $signed(av << (64 - w)) >>> (64 - w);
            sb = $signed(bv << (64 - w)) >>> (64 - w);
            mn = -(longint'(1) << (w - 1));
            o  = (sa == mn) && (sb == -1);
            q  = sa / sb;
            r  = sa % sb;
            q  = q & mask;
            r  = r & mask;
        end
    endtask

    // One operation with a start pulse; operands are scrambled right after
    // acceptance. lat counts edges after the accepting edge until ready.
    task automatic run_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                          input logic sv, output logic [63:0] q, output logic [63:0] r,
                          output logic z, output logic o, output int lat);
        int guard;
        guard = 0;
        while (!cur_ready(w) && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        drive(w, av, bv, sv, 1'b1);
        @(posedge clk); #1;
        drive(w, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!cur_ready(w) && lat < 200);
        read_out(w, q, r, z, o);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        vectors++;
        if ({quot32, rem32, dbz32, ovf32, ready32} !== {64'd0, 3'b001}) begin
            miscompares++;
            $display("[TB] FAIL reset32: got %h required %h",
                     {quot32, rem32, dbz32, ovf32, ready32}, {64'd0, 3'b001});
        end
        vectors++;
        if ({quot8, rem8, dbz8, ovf8, ready8} !== {16'd0, 3'b001}) begin
            miscompares++;
            $display("[TB] FAIL reset8: got %h required %h",
                     {quot8, rem8, dbz8, ovf8, ready8}, {16'd0, 3'b001});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [63:0] q, r;
        logic z, o;
        int lat;
        run_op(32, 64'd100, 64'd7, 1'b0, q, r, z, o, lat);
        vectors++;
        if (lat !== 33) begin
            miscompares++;
            $display("[TB] FAIL latency_100_7: got %0d required 33", lat);
        end
        vectors++;
        if ({q, r, z, o} !== {64'd14, 64'd2, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL div_100_7: got q=%h r=%h dbz=%b ovf=%b required q=14 r=2", q, r, z, o);
        end
        run_op(32, 64'hFFFFFFF9, 64'd2, 1'b1, q, r, z, o, lat);
        vectors++;
        if ({q, r, z, o} !== {64'hFFFFFFFD, 64'hFFFFFFFF, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL signed_m7_2: got q=%h r=%h dbz=%b ovf=%b required q=fffffffd r=ffffffff", q, r, z, o);
        end
        run_op(32, 64'hFFFFFFF9, 64'd2, 1'b0, q, r, z, o, lat);
        vectors++;
        if ({q, r, z, o} !== {64'h7FFFFFFC, 64'd1, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL unsigned_m7_2: got q=%h r=%h dbz=%b ovf=%b required q=7ffffffc r=1", q, r, z, o);
        end
    endtask

    task automatic test_dbz;
        logic [63:0] q, r;
        logic z, o;
        int lat;
        for (int s = 0; s < 2; s++) begin
            run_op(32, 64'h12345678, 64'd0, 1'(s), q, r, z, o, lat);
            vectors++;
            if (lat !== 1) begin
                miscompares++;
                $display("[TB] FAIL dbz_latency sign=%0d: got %0d required 1", s, lat);
            end
            vectors++;
            if ({q, r, z, o} !== {64'hFFFFFFFF, 64'h12345678, 2'b10}) begin
                miscompares++;
                $display("[TB] FAIL dbz sign=%0d: got q=%h r=%h dbz=%b ovf=%b required q=ffffffff r=12345678 dbz=1", s, q, r, z, o);
            end
        end
        run_op(32, 64'd20, 64'd5, 1'b0, q, r, z, o, lat);
        vectors++;
        if ({q, r, z, o} !== {64'd4, 64'd0, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL dbz_clear: got q=%h r=%h dbz=%b ovf=%b required q=4 r=0 dbz=0", q, r, z, o);
        end
    endtask

    task automatic test_overflow;
        logic [63:0] q, r;
        logic z, o;
        int lat;
        run_op(8, 64'h80, 64'hFF, 1'b1, q, r, z, o, lat);
        vectors++;
        if (lat !== 9) begin
            miscompares++;
            $display("[TB] FAIL latency_w8: got %0d required 9", lat);
        end
        vectors++;
        if ({q, r, z, o} !== {64'h80, 64'd0, 2'b01}) begin
            miscompares++;
            $display("[TB] FAIL ovf_signed: got q=%h r=%h dbz=%b ovf=%b required q=80 r=0 ovf=1", q, r, z, o);
        end
        run_op(8, 64'h80, 64'hFF, 1'b0, q, r, z, o, lat);
        vectors++;
        if ({q, r, z, o} !== {64'd0, 64'h80, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL ovf_unsigned: got q=%h r=%h dbz=%b ovf=%b required q=0 r=80 ovf=0", q, r, z, o);
        end
    endtask

    task automatic test_reset_abort;
        logic [63:0] q, r;
        logic z, o;
        int lat;
        drive(32, 64'd1000, 64'd3, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(32, 64'd0, 64'd0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({quot32, rem32, dbz32, ovf32, ready32} !== {64'd0, 3'b001}) begin
            miscompares++;
            $display("[TB] FAIL reset_abort: got %h required %h",
                     {quot32, rem32, dbz32, ovf32, ready32}, {64'd0, 3'b001});
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        drive(32, 64'd9, 64'd3, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(32, 64'd0, 64'd0, 1'b0, 1'b0);
        lat = 0;
        do begin
            if (lat == 2) drive(32, 64'd50, 64'd5, 1'b0, 1'b1);
            else if (lat == 3) drive(32, 64'd0, 64'd0, 1'b0, 1'b0);
            @(posedge clk); #1; lat++;
        end while (!ready32 && lat < 200);
        read_out(32, q, r, z, o);
        vectors++;
        if (lat !== 33) begin
            miscompares++;
            $display("[TB] FAIL busy_start_latency: got %0d required 33", lat);
        end
        vectors++;
        if ({q, r, z, o} !== {64'd3, 64'd0, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL restart_9_3: got q=%h r=%h dbz=%b ovf=%b required q=3 r=0", q, r, z, o);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({ready32, quot32} !== {1'b1, 32'd3}) begin
            miscompares++;
            $display("[TB] FAIL busy_start_ignored: got ready=%b q=%h required ready=1 q=3", ready32, quot32);
        end
    endtask

    // Random operations with start held high the whole time; the bench sets
    // fresh operands in the single idle cycle between operations.
    task automatic test_back_to_back(input int w, input logic sv, input int n);
        logic [63:0] av, bv, q, r, eq, er;
        logic z, o, ez, eo;
        int lat, elat, k, guard;
        guard = 0;
        while (!cur_ready(w) && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        for (int i = 0; i < n; i++) begin
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            k  = $urandom_range(0, 15);
            if (k == 0) bv = 64'd0;
            else if (k == 1) begin av = 64'd1 << (w - 1); bv = '1; end
            else if (k == 2) begin av = av & 64'hFF; bv = bv & 64'hF; end
            else if (k == 3) bv = bv & 64'h3;
            ref_div(w, av, bv, sv, eq, er, ez, eo);
            elat = ez ? 1 : w + 1;
            drive(w, av, bv, sv, 1'b1);
            @(posedge clk); #1;
            vectors++;
            if (cur_ready(w) !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL b2b_accept w=%0d op=%0d: got ready=%b required 0", w, i, cur_ready(w));
            end
            drive(w, {$urandom, $urandom}, {$urandom, $urandom}, ~sv, 1'b1);
            lat = 0;
            do begin
                @(posedge clk); #1; lat++;
            end while (!cur_ready(w) && lat < 200);
            read_out(w, q, r, z, o);
            vectors++;
            if (lat !== elat) begin
                miscompares++;
                $display("[TB] FAIL b2b_latency w=%0d op=%0d: got %0d required %0d", w, i, lat, elat);
            end
            vectors++;
            if ({q, r, z, o} !== {eq, er, ez, eo}) begin
                miscompares++;
                $display("[TB] FAIL b2b_result w=%0d sign=%b a=%h b=%h: got q=%h r=%h dbz=%b ovf=%b required q=%h r=%h dbz=%b ovf=%b",
                         w, sv, av, bv, q, r, z, o, eq, er, ez, eo);
            end
        end
        drive(w, 64'd0, 64'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        drive(32, 64'd0, 64'd0, 1'b0, 1'b0);
        drive(8, 64'd0, 64'd0, 1'b0, 1'b0);
        test_reset;
        test_directed;
        test_dbz;
        test_overflow;
        test_reset_abort;
        test_back_to_back(8, 1'b0, 1000);
        test_back_to_back(8, 1'b1, 1000);
        test_back_to_back(32, 1'b0, 250);
        test_back_to_back(32, 1'b1, 250);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
